// File: rtl/count_bcd_display.sv
// Shows a binary count in decimal on a multiplexed common-anode 7-segment display.
// Serial shift-add-3 conversion on every input change, continuous digit scan with leading-zero blanking.
module count_bcd_display #(
    parameter int N        = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N-1:0]      Q_in,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              bcd_valid,
    output logic              busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic longint unsigned pow10(input int e);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    generate
        if (pow10(DIGITS) <= ((64'd1 << N) - 64'd1)) begin : g_range_check
            $error("count_bcd_display: DIGITS too small for an N-bit count");
        end
    endgenerate

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t         state_reg,   state_next;
    logic [N-1:0]   shift_reg,   shift_next;
    logic [BW-1:0]  bcd_reg,     bcd_next;
    logic [BW-1:0]  disp_reg,    disp_next;
    logic [N-1:0]   last_reg,    last_next;
    logic           pending_reg, pending_next;
    logic [CW-1:0]  cnt_reg,     cnt_next;
    logic           valid_reg,   valid_next;
    logic [IW-1:0]  idx_reg,     idx_next;
    logic [DW-1:0]  div_reg,     div_next;

    logic [BW-1:0]   bcd_adj;
    logic [BW+N-1:0] combo;
    logic [3:0]      nibs [DIGITS];
    logic [DIGITS-1:0] blank;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
            assign nibs[gi] = disp_reg[gi*4 +: 4];
            // A digit is blank when it and every digit above it are zero; digit 0 always shows.
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = (disp_reg[BW-1:gi*4] == '0);
            end
        end
    endgenerate

    assign combo = {bcd_adj, shift_reg} << 1;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bcd_reg     <= '0;
            disp_reg    <= '0;
            last_reg    <= '0;
            pending_reg <= 1'b1;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bcd_reg     <= bcd_next;
            disp_reg    <= disp_next;
            last_reg    <= last_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bcd_next     = bcd_reg;
        disp_next    = disp_reg;
        last_next    = last_reg;
        pending_next = pending_reg;
        cnt_next     = cnt_reg;
        valid_next   = valid_reg;
        case (state_reg)
            IDLE: begin
                if (pending_reg || (Q_in != last_reg)) begin
                    shift_next   = Q_in;
                    last_next    = Q_in;
                    bcd_next     = '0;
                    cnt_next     = '0;
                    pending_next = 1'b0;
                    state_next   = CONVERT;
                end
            end
            CONVERT: begin
                bcd_next   = combo[BW+N-1:N];
                shift_next = combo[N-1:0];
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CW'(N - 1)) state_next = LOAD;
            end
            LOAD: begin
                disp_next  = bcd_reg;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else begin
            div_reg <= div_next;
            idx_reg <= idx_next;
        end
    end

    always_comb begin
        div_next = div_reg + 1'b1;
        idx_next = idx_reg;
        if (div_reg == DW'(SCAN_DIV - 1)) begin
            div_next = '0;
            idx_next = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end
    end

    always_comb begin
        an  = '1;
        seg = 7'h7F;
        if (valid_reg) begin
            an = ~(DIGITS'(1) << idx_reg);
            if (!blank[idx_reg]) seg = seg_code(nibs[idx_reg]);
        end
    end

    assign busy      = (state_reg != IDLE);
    assign bcd_valid = valid_reg;

endmodule

// File: tb/tb_count_bcd_display.sv
// Scoreboard bench: stimulus queues expected loads, a negedge monitor checks load timing and the scanned display.
module tb_count_bcd_display;
    localparam int N        = 4;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int LAT      = N + 2;

    logic              clk = 1'b0;
    logic              clr;
    logic [N-1:0]      Q_in;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              bcd_valid;
    logic              busy;

    count_bcd_display #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .clr(clr), .Q_in(Q_in), .seg(seg),
        .an(an), .bcd_valid(bcd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int cyc; } exp_t;
    exp_t exp_q[$];

    int   cyc = 0;
    logic clr_q = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   done_req = 0;
    bit   done_ack = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        clr_q <= clr;
    end

    function automatic logic [6:0] exp_seg(int v, int d);
        int nib;
        if (d > 0 && v < 10) return 7'h7F;
        nib = (d == 0) ? v % 10 : (v / 10) % 10;
        case (nib)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    bit         model_valid = 0;
    int         model_val = 0;
    logic       busy_prev = 1'b0;
    logic [1:0] prev_an = 2'b11;
    bit         have_prev = 0;
    bit         run_known = 0;
    int         run = 0;
    int         dig;
    int         exp_busy;
    exp_t       head;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (!clr_q) begin
                exp_q.delete();
                model_valid = 0;
                have_prev   = 0;
                run_known   = 0;
            end else if (busy_prev && !busy && bcd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 1, 0);
                end else begin
                    head = exp_q.pop_front();
                    check("load_cycle", cyc, head.cyc);
                    $display("[TB] load value %0d at cycle %0d", head.val, cyc);
                    model_val   = head.val;
                    model_valid = 1;
                end
            end

            exp_busy = 0;
            if (exp_q.size() > 0 && cyc >= exp_q[0].cyc - (N + 1) && cyc < exp_q[0].cyc)
                exp_busy = 1;
            check("busy", int'(busy), exp_busy);
            check("bcd_valid", int'(bcd_valid), int'(model_valid));

            if (model_valid) begin
                dig = (an == 2'b01) ? 1 : 0;
                check("anode_onehot", int'(an == 2'b10 || an == 2'b01), 1);
                check($sformatf("seg_digit%0d", dig), int'(seg), int'(exp_seg(model_val, dig)));
                if (!have_prev) begin
                    run       = 1;
                    have_prev = 1;
                end else if (an != prev_an) begin
                    if (run_known) check("scan_period", run, SCAN_DIV);
                    run_known = 1;
                    run       = 1;
                end else begin
                    run++;
                end
                prev_an = an;
            end else begin
                check("an_off", int'(an), 3);
                check("seg_off", int'(seg), 'h7F);
                have_prev = 0;
                run_known = 0;
            end
            busy_prev = busy;

            if (done_req && !done_ack) begin
                check("queue_drained", exp_q.size(), 0);
                done_ack = 1;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_load(int v, int at);
        exp_t e;
        e.val = v;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic convert(int v, int hold);
        Q_in = N'(v);
        expect_load(v, cyc + LAT);
        tick(LAT + hold);
    endtask

    task automatic release_reset(int v);
        clr = 1'b1;
        @(negedge clk);
        #1;
        expect_load(v, cyc + LAT);
    endtask

    int c;

    initial begin
        clr  = 1'b0;
        Q_in = 4'd9;
        tick(3);

        // Reset release with pending capture of 9
        release_reset(9);
        tick(10);

        convert(13, 20);
        convert(15, 12);
        convert(0, 12);

        // 3 captured, 7 and 9 arrive mid-conversion; only 9 follows
        Q_in = 4'd3;
        c = cyc;
        expect_load(3, c + LAT);
        tick(1);
        Q_in = 4'd7;
        tick(2);
        Q_in = 4'd9;
        expect_load(9, c + 2 * LAT);
        tick(16);

        // Abort conversion of 5 with reset in its third CONVERT cycle
        Q_in = 4'd5;
        expect_load(5, cyc + LAT);
        tick(3);
        clr = 1'b0;
        tick(1);
        release_reset(5);
        tick(12);

        // Idle stretch with constant input
        tick(50);

        done_req = 1;
        for (int i = 0; i < 8 && !done_ack; i++) @(posedge clk);
        if (!done_ack) begin
            $display("FAIL monitor_timeout: got no drain acknowledge, expected one within 8 cycles");
            $fatal(1, "monitor did not respond");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
